// File: rtl/clk_gen_pkg.sv
// Shared types for the multi-channel clock divider.
// Output modes, channel states and the reset divisor default.
package clk_gen_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int RST_DIV_DEF = 10000;

endpackage

// File: rtl/clk_div_cfg_if.sv
// Per-channel configuration bundle: write strobe, divisor, mode,
// restart strobe. Master drives, channel (slave) consumes.
interface clk_div_cfg_if
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = 28
) ();

  logic             we;
  logic             restart;
  logic [CNT_W-1:0] div;
  mode_e            mode;

  modport master (
    output we,
    output restart,
    output div,
    output mode
  );

  modport slave (
    input we,
    input restart,
    input div,
    input mode
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active config, IDLE/RUN FSM.
// Ports: clk100MHz, rst, en, cfg (slave), tick, clk_out.
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int CNT_W   = 28,
  parameter int RST_DIV = RST_DIV_DEF
) (
  input  logic          clk100MHz,
  input  logic          rst,
  input  logic          en,
  clk_div_cfg_if.slave  cfg,
  output logic          tick,
  output logic          clk_out
);

  localparam logic [CNT_W-1:0] DIV0 =
    CNT_W'(RST_DIV);

  ch_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] act_div, act_div_n;
  logic [CNT_W-1:0] sh_div, sh_div_n;
  mode_e            act_mode, act_mode_n;
  mode_e            sh_mode, sh_mode_n;
  logic             tick_n, clk_n;
  logic             pulse;

  assign pulse = (act_mode == MODE_PULSE);

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      act_div  <= DIV0;
      sh_div   <= DIV0;
      act_mode <= MODE_TOGGLE;
      sh_mode  <= MODE_TOGGLE;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      act_div  <= act_div_n;
      sh_div   <= sh_div_n;
      act_mode <= act_mode_n;
      sh_mode  <= sh_mode_n;
      tick     <= tick_n;
      clk_out  <= clk_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    act_div_n  = act_div;
    act_mode_n = act_mode;
    sh_div_n   = sh_div;
    sh_mode_n  = sh_mode;
    tick_n     = 1'b0;
    clk_n      = clk_out;
    if (cfg.we) begin
      sh_div_n  = cfg.div;
      sh_mode_n = cfg.mode;
    end
    if (cfg.restart) begin
      // A coincident write is made active here too.
      cnt_n      = '0;
      clk_n      = 1'b0;
      act_div_n  = sh_div_n;
      act_mode_n = sh_mode_n;
      state_n    = (en && act_div_n != '0)
                   ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n      = '0;
          act_div_n  = sh_div;
          act_mode_n = sh_mode;
          if (pulse) clk_n = 1'b0;
          if (en && act_div != '0)
            state_n = RUN;
        end
        RUN: begin
          if (!en || act_div == '0) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (pulse) clk_n = 1'b0;
          end else if (cnt == act_div - 1'b1) begin
            // Wrap: swap in shadow from the
            // previous cycle, not this one.
            cnt_n      = '0;
            tick_n     = 1'b1;
            clk_n      = pulse ? 1'b1 : ~clk_out;
            act_div_n  = sh_div;
            act_mode_n = sh_mode;
          end else begin
            cnt_n = cnt + 1'b1;
            if (pulse) clk_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent clock dividers sharing one cfg bus and restart.
// Ports: clk100MHz, rst, ch_en, cfg_*, sync_restart, tick, clk_out.
module clk_div_multi
  import clk_gen_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 28,
  parameter  int RST_DIV = RST_DIV_DEF,
  localparam int CH_W    =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk100MHz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_cfg_if #(.CNT_W(CNT_W)) cif ();

    // Out-of-range cfg_ch matches no channel.
    assign cif.we      = cfg_we &&
                         (cfg_ch == CH_W'(i));
    assign cif.restart = sync_restart;
    assign cif.div     = cfg_div;
    assign cif.mode    = mode_e'(cfg_mode);

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_chan (
      .clk100MHz (clk100MHz),
      .rst       (rst),
      .en        (ch_en[i]),
      .cfg       (cif),
      .tick      (tick[i]),
      .clk_out   (clk_out[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi (NUM_CH=2, CNT_W=8, RST_DIV=4).
// Expected tick cycles are queued per scenario and popped per edge.
module tb_clk_div_multi;
  import clk_gen_pkg::*;

  logic       clk100MHz = 1'b0;
  logic       rst;
  logic [1:0] ch_en;
  logic       cfg_ch;
  logic [1:0] tick;
  logic [1:0] clk_out;

  clk_div_cfg_if #(.CNT_W(8)) bus ();

  int tests = 0;
  int fails = 0;
  int exp_q[2][$];
  logic [1:0] ec;
  logic [1:0] pm;

  always #5 clk100MHz = ~clk100MHz;

  clk_div_multi #(
    .NUM_CH  (2),
    .CNT_W   (8),
    .RST_DIV (4)
  ) dut (
    .clk100MHz    (clk100MHz),
    .rst          (rst),
    .ch_en        (ch_en),
    .cfg_we       (bus.we),
    .cfg_ch       (cfg_ch),
    .cfg_div      (bus.div),
    .cfg_mode     (bus.mode),
    .sync_restart (bus.restart),
    .tick         (tick),
    .clk_out      (clk_out)
  );

  task automatic step();
    @(posedge clk100MHz);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    ch_en       = 2'b00;
    cfg_ch      = 1'b0;
    bus.we      = 1'b0;
    bus.restart = 1'b0;
    bus.div     = 8'd0;
    bus.mode    = MODE_TOGGLE;
    step();
    step();
    rst = 1'b0;
    ec  = 2'b00;
    pm  = 2'b00;
    exp_q[0].delete();
    exp_q[1].delete();
  endtask

  task automatic test_reset();
    do_reset();
    rst         = 1'b1;
    ch_en       = 2'b11;
    bus.we      = 1'b1;
    bus.div     = 8'd1;
    bus.restart = 1'b1;
    step();
    tests++;
    if (tick !== 2'b00) begin
      fails++;
      $display("FAIL rst_tick: got %b want 00",
               tick);
    end
    tests++;
    if (clk_out !== 2'b00) begin
      fails++;
      $display("FAIL rst_clk: got %b want 00",
               clk_out);
    end
    rst         = 1'b0;
    ch_en       = 2'b00;
    bus.we      = 1'b0;
    bus.restart = 1'b0;
    step();
    tests++;
    if ({tick, clk_out} !== 4'b0000) begin
      fails++;
      $display("FAIL idle_out: got %b want 0000",
               {tick, clk_out});
    end
  endtask

  task automatic test_basic();
    logic et;
    do_reset();
    for (int t = 4; t <= 16; t += 4)
      exp_q[0].push_back(t);
    ch_en = 2'b01;
    for (int k = 0; k < 18; k++) begin
      step();
      for (int c = 0; c < 2; c++) begin
        et = exp_q[c].size() > 0 &&
             exp_q[c][0] == k;
        if (et) void'(exp_q[c].pop_front());
        if (pm[c]) ec[c] = et;
        else if (et) ec[c] = ~ec[c];
        tests++;
        if (tick[c] !== et) begin
          fails++;
          $display("FAIL basic_tick%0d cyc %0d: got %b want %b",
                   c, k, tick[c], et);
        end
        tests++;
        if (clk_out[c] !== ec[c]) begin
          fails++;
          $display("FAIL basic_clk%0d cyc %0d: got %b want %b",
                   c, k, clk_out[c], ec[c]);
        end
      end
    end
    tests++;
    if (exp_q[0].size() + exp_q[1].size() != 0) begin
      fails++;
      $display("FAIL basic_left: got %0d want 0",
               exp_q[0].size() + exp_q[1].size());
    end
  endtask

  task automatic test_reconfig();
    logic et;
    do_reset();
    exp_q[0] = {4, 8, 10, 12, 14};
    ch_en   = 2'b01;
    cfg_ch  = 1'b0;
    bus.div = 8'd2;
    for (int k = 0; k < 16; k++) begin
      bus.we = (k == 5);
      step();
      for (int c = 0; c < 2; c++) begin
        et = exp_q[c].size() > 0 &&
             exp_q[c][0] == k;
        if (et) void'(exp_q[c].pop_front());
        if (pm[c]) ec[c] = et;
        else if (et) ec[c] = ~ec[c];
        tests++;
        if (tick[c] !== et) begin
          fails++;
          $display("FAIL recfg_tick%0d cyc %0d: got %b want %b",
                   c, k, tick[c], et);
        end
        tests++;
        if (clk_out[c] !== ec[c]) begin
          fails++;
          $display("FAIL recfg_clk%0d cyc %0d: got %b want %b",
                   c, k, clk_out[c], ec[c]);
        end
      end
    end
    bus.we = 1'b0;
    tests++;
    if (exp_q[0].size() + exp_q[1].size() != 0) begin
      fails++;
      $display("FAIL recfg_left: got %0d want 0",
               exp_q[0].size() + exp_q[1].size());
    end
  endtask

  task automatic test_pulse();
    logic et;
    do_reset();
    for (int t = 3; t <= 11; t++)
      exp_q[1].push_back(t);
    pm       = 2'b10;
    cfg_ch   = 1'b1;
    bus.mode = MODE_PULSE;
    for (int k = 0; k < 16; k++) begin
      bus.we  = (k == 0) || (k == 10);
      bus.div = (k < 5) ? 8'd1 : 8'd0;
      ch_en   = (k >= 2) ? 2'b10 : 2'b00;
      step();
      for (int c = 0; c < 2; c++) begin
        et = exp_q[c].size() > 0 &&
             exp_q[c][0] == k;
        if (et) void'(exp_q[c].pop_front());
        if (pm[c]) ec[c] = et;
        else if (et) ec[c] = ~ec[c];
        tests++;
        if (tick[c] !== et) begin
          fails++;
          $display("FAIL pulse_tick%0d cyc %0d: got %b want %b",
                   c, k, tick[c], et);
        end
        tests++;
        if (clk_out[c] !== ec[c]) begin
          fails++;
          $display("FAIL pulse_clk%0d cyc %0d: got %b want %b",
                   c, k, clk_out[c], ec[c]);
        end
      end
    end
    bus.we = 1'b0;
    tests++;
    if (exp_q[0].size() + exp_q[1].size() != 0) begin
      fails++;
      $display("FAIL pulse_left: got %0d want 0",
               exp_q[0].size() + exp_q[1].size());
    end
  endtask

  task automatic test_sync();
    logic et;
    do_reset();
    exp_q[0] = {6, 9, 12, 14, 16, 18, 20};
    exp_q[1] = {8, 15, 20};
    for (int k = 0; k < 22; k++) begin
      cfg_ch      = (k == 1);
      bus.we      = (k == 0) || (k == 1) ||
                    (k == 10);
      bus.div     = (k == 0) ? 8'd3 :
                    (k == 1) ? 8'd5 : 8'd2;
      ch_en       = (k >= 3) ? 2'b11 : 2'b00;
      bus.restart = (k == 10);
      step();
      if (k == 10) ec = 2'b00;
      for (int c = 0; c < 2; c++) begin
        et = exp_q[c].size() > 0 &&
             exp_q[c][0] == k;
        if (et) void'(exp_q[c].pop_front());
        if (pm[c]) ec[c] = et;
        else if (et) ec[c] = ~ec[c];
        tests++;
        if (tick[c] !== et) begin
          fails++;
          $display("FAIL sync_tick%0d cyc %0d: got %b want %b",
                   c, k, tick[c], et);
        end
        tests++;
        if (clk_out[c] !== ec[c]) begin
          fails++;
          $display("FAIL sync_clk%0d cyc %0d: got %b want %b",
                   c, k, clk_out[c], ec[c]);
        end
      end
    end
    bus.we      = 1'b0;
    bus.restart = 1'b0;
    tests++;
    if (exp_q[0].size() + exp_q[1].size() != 0) begin
      fails++;
      $display("FAIL sync_left: got %0d want 0",
               exp_q[0].size() + exp_q[1].size());
    end
  endtask

  task automatic test_rst_mid();
    logic et;
    do_reset();
    exp_q[0] = {4, 12, 16};
    ch_en   = 2'b01;
    cfg_ch  = 1'b0;
    bus.div = 8'd2;
    for (int k = 0; k < 18; k++) begin
      rst    = (k == 7);
      bus.we = (k == 7);
      step();
      if (k == 7) ec = 2'b00;
      for (int c = 0; c < 2; c++) begin
        et = exp_q[c].size() > 0 &&
             exp_q[c][0] == k;
        if (et) void'(exp_q[c].pop_front());
        if (pm[c]) ec[c] = et;
        else if (et) ec[c] = ~ec[c];
        tests++;
        if (tick[c] !== et) begin
          fails++;
          $display("FAIL rstmid_tick%0d cyc %0d: got %b want %b",
                   c, k, tick[c], et);
        end
        tests++;
        if (clk_out[c] !== ec[c]) begin
          fails++;
          $display("FAIL rstmid_clk%0d cyc %0d: got %b want %b",
                   c, k, clk_out[c], ec[c]);
        end
      end
    end
    rst    = 1'b0;
    bus.we = 1'b0;
    tests++;
    if (exp_q[0].size() + exp_q[1].size() != 0) begin
      fails++;
      $display("FAIL rstmid_left: got %0d want 0",
               exp_q[0].size() + exp_q[1].size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reconfig();
    test_pulse();
    test_sync();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
